// File: rtl/fifo_arb_pkg.sv
// Shared types, widths and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // Widths for the default configuration (4 producers, 8-beat cap).
   localparam int unsigned NUM_REQ_DEF   = 4;
   localparam int unsigned MAX_BURST_DEF = 8;
   localparam int unsigned ID_W          = $clog2(NUM_REQ_DEF);
   localparam int unsigned CNT_W         = $clog2(MAX_BURST_DEF + 1);

   // Producer index width for an arbitrary producer count.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Beat counter width able to hold 0..max_burst.
   function automatic int unsigned cnt_width(input int unsigned max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic             found_o,
   output logic [IDX_W-1:0] index_o
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   int unsigned    sum;

   // Rotate the request vector so ptr_i lands at bit 0, then take the lowest set bit.
   always_comb begin
      dbl     = {req_i, req_i};
      rot     = N'(dbl >> ptr_i);
      found_o = |rot;
      sum     = 32'(ptr_i);
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            sum = 32'(ptr_i) + unsigned'(k);
         end
      end
      if (sum >= N) begin
         sum = sum - N;
      end
      index_o = IDX_W'(sum);
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-granular arbiter sharing one FIFO write port between producers.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_BURST = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic [NUM_REQ-1:0]          req_last,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        fifo_wr_en,
   output logic [DATA_W-1:0]           fifo_wr_data,
   input  logic                        fifo_full,
   input  logic                        fifo_almost_full,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id,
   output logic                        busy
);

   localparam int unsigned GW = id_width(NUM_REQ);
   localparam int unsigned BW = cnt_width(MAX_BURST);

   arb_state_e      state_q;
   logic [GW-1:0]   grant_id_q;
   logic [GW-1:0]   rr_ptr_q;
   logic [BW-1:0]   beat_cnt_q;

   logic            pick_found;
   logic [GW-1:0]   pick_idx;
   logic [GW-1:0]   next_ptr;
   logic            in_burst;
   logic            gnt_valid;
   logic            gnt_last;
   logic [DATA_W-1:0] gnt_data;
   logic            xfer;
   logic            burst_end;
   logic            arb_go;

   rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (GW)
   ) u_rr_pick (
      .req_i   (req_valid),
      .ptr_i   (rr_ptr_q),
      .found_o (pick_found),
      .index_o (pick_idx)
   );

   // Select the granted producer's lane and derive transfer / release / arbitration strobes.
   always_comb begin
      in_burst  = (state_q == BURST);
      gnt_valid = 1'b0;
      gnt_last  = 1'b0;
      gnt_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id_q == GW'(i)) begin
            gnt_valid = req_valid[i];
            gnt_last  = req_last[i];
            gnt_data  = req_data[i*DATA_W +: DATA_W];
         end
      end
      xfer      = in_burst & gnt_valid & ~fifo_full;
      burst_end = xfer & (gnt_last | (beat_cnt_q == BW'(MAX_BURST - 1)));
      arb_go    = ~in_burst & pick_found & ~fifo_almost_full;
      next_ptr  = (pick_idx == GW'(NUM_REQ - 1)) ? '0 : pick_idx + GW'(1);
   end

   // Zero-latency write-port pass-through while a grant is active.
   always_comb begin
      req_ready    = '0;
      fifo_wr_en   = 1'b0;
      fifo_wr_data = '0;
      busy         = in_burst;
      if (in_burst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = xfer & (grant_id_q == GW'(i));
         end
         fifo_wr_en   = xfer;
         fifo_wr_data = gnt_data;
      end
   end

   // Arbitration FSM: grant in IDLE, count beats and release in BURST.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_id_q <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arb_go) begin
                  grant_id_q <= pick_idx;
                  rr_ptr_q   <= next_ptr;
                  beat_cnt_q <= '0;
                  state_q    <= BURST;
               end
            end
            BURST: begin
               if (xfer) begin
                  beat_cnt_q <= beat_cnt_q + BW'(1);
                  if (burst_end) begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign grant_id = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic vs a packet-level model.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int MB = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      req_last;
   logic [N-1:0]      req_ready;
   logic              fifo_wr_en;
   logic [DW-1:0]     fifo_wr_data;
   logic              fifo_full;
   logic              fifo_almost_full;
   logic [1:0]        grant_id;
   logic              busy;

   fifo_wr_arbiter #(
      .NUM_REQ   (N),
      .DATA_W    (DW),
      .MAX_BURST (MB)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_data         (req_data),
      .req_last         (req_last),
      .req_ready        (req_ready),
      .fifo_wr_en       (fifo_wr_en),
      .fifo_wr_data     (fifo_wr_data),
      .fifo_full        (fifo_full),
      .fifo_almost_full (fifo_almost_full),
      .grant_id         (grant_id),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   int vectors;
   int miscompares;

   // Producer beat queues: data and last flag per beat.
   logic [DW-1:0] qd [N][$];
   bit            ql [N][$];
   logic [N-1:0]  en;
   int            seq [N];
   logic [DW-1:0] drv [N];

   // Reference model: current owner (-1 = no grant), rotation pointer, beats in grant, last owner.
   int owner;
   int ptr;
   int cnt;
   int last_g;
   bit exp_xfer;

   int dut_grants[$];
   bit prev_busy;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic add_pkt(input int p, input int beats, input bit with_last);
      for (int b = 0; b < beats; b++) begin
         qd[p].push_back({8'(p), 24'(seq[p])});
         ql[p].push_back(with_last && (b == beats - 1));
         seq[p]++;
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         drv[i]                 = (qd[i].size() > 0) ? qd[i][0] : '0;
         req_valid[i]           = en[i] && (qd[i].size() > 0);
         req_last[i]            = (qd[i].size() > 0) ? ql[i][0] : 1'b0;
         req_data[i*DW +: DW]   = drv[i];
      end
   endtask

   task automatic compare();
      logic [N-1:0] er;
      exp_xfer = (owner >= 0) && req_valid[owner] && !fifo_full;
      er = exp_xfer ? N'(1 << owner) : '0;
      chk("busy",     64'(busy),         64'(owner >= 0));
      chk("wr_en",    64'(fifo_wr_en),   64'(exp_xfer));
      chk("ready",    64'(req_ready),    64'(er));
      chk("wr_data",  64'(fifo_wr_data), (owner >= 0) ? 64'(drv[owner]) : 64'(0));
      chk("grant_id", 64'(grant_id),     (owner >= 0) ? 64'(owner) : 64'(last_g));
      if (busy && !prev_busy) dut_grants.push_back(int'(grant_id));
      prev_busy = busy;
   endtask

   task automatic model_edge();
      bit l;
      int c;
      if (owner >= 0) begin
         if (exp_xfer) begin
            l = ql[owner].pop_front();
            void'(qd[owner].pop_front());
            cnt++;
            if (l || cnt == MB) owner = -1;
         end
      end else if (req_valid != '0 && !fifo_almost_full) begin
         for (int k = 0; k < N; k++) begin
            c = (ptr + k) % N;
            if (req_valid[c] && owner < 0) owner = c;
         end
         last_g = owner;
         ptr    = (owner + 1) % N;
         cnt    = 0;
      end
   endtask

   // One cycle: drive at posedge+1, check at posedge+3, advance model at the edge.
   task automatic step();
      drive();
      #2;
      compare();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_busy",  64'(busy),         64'(0));
      chk("rst_wr_en", 64'(fifo_wr_en),   64'(0));
      chk("rst_ready", 64'(req_ready),    64'(0));
      chk("rst_data",  64'(fifo_wr_data), 64'(0));
      chk("rst_grant", 64'(grant_id),     64'(0));
      for (int i = 0; i < N; i++) begin
         qd[i].delete();
         ql[i].delete();
      end
      owner = -1; ptr = 0; cnt = 0; last_g = 0;
      prev_busy = 1'b0;
      en = '0; fifo_full = 1'b0; fifo_almost_full = 1'b0;
      dut_grants.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int ord_fair[6];
      int ord_cap[4];
      int p;
      vectors = 0; miscompares = 0;
      for (int i = 0; i < N; i++) seq[i] = 0;
      rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
      fifo_full = 1'b0; fifo_almost_full = 1'b0; en = '0;
      owner = -1; ptr = 0; cnt = 0; last_g = 0; prev_busy = 1'b0;
      #1;
      do_reset();

      // Single 3-beat packet from producer 0.
      add_pkt(0, 3, 1'b1);
      en = 4'b0001;
      repeat (6) step();
      chk("single_grants", 64'(dut_grants.size()), 64'(1));
      if (dut_grants.size() > 0) chk("single_gid", 64'(dut_grants[0]), 64'(0));

      // Fairness with 2-beat packets from all producers.
      do_reset();
      for (int i = 0; i < N; i++) begin
         add_pkt(i, 2, 1'b1);
         add_pkt(i, 2, 1'b1);
      end
      en = 4'b1111;
      repeat (30) step();
      ord_fair = '{0, 1, 2, 3, 0, 1};
      chk("fair_count", 64'(dut_grants.size() >= 6), 64'(1));
      if (dut_grants.size() >= 6)
         for (int i = 0; i < 6; i++) chk("fair_order", 64'(dut_grants[i]), 64'(ord_fair[i]));

      // Burst cap: long packet from 0 is rotated out in favour of 1.
      do_reset();
      add_pkt(0, 20, 1'b1);
      add_pkt(1, 1, 1'b1);
      en = 4'b0011;
      repeat (40) step();
      ord_cap = '{0, 1, 0, 0};
      chk("cap_count", 64'(dut_grants.size()), 64'(4));
      if (dut_grants.size() >= 4)
         for (int i = 0; i < 4; i++) chk("cap_order", 64'(dut_grants[i]), 64'(ord_cap[i]));

      // Full stall for 3 cycles after beat 2.
      do_reset();
      add_pkt(2, 5, 1'b1);
      en = 4'b0100;
      repeat (3) step();
      fifo_full = 1'b1;
      repeat (3) step();
      fifo_full = 1'b0;
      repeat (5) step();

      // Almost-full blocks a new grant while idle.
      do_reset();
      add_pkt(1, 2, 1'b1);
      add_pkt(2, 2, 1'b1);
      en = 4'b0110;
      fifo_almost_full = 1'b1;
      repeat (4) step();
      fifo_almost_full = 1'b0;
      repeat (8) step();
      if (dut_grants.size() > 0) chk("af_first", 64'(dut_grants[0]), 64'(1));
      else chk("af_first_seen", 64'(0), 64'(1));

      // Asynchronous reset at beat 4 of a producer-2 burst.
      do_reset();
      add_pkt(2, 8, 1'b1);
      en = 4'b0100;
      repeat (4) step();
      drive();
      #1;
      compare();
      chk("pre_rst_wr_en", 64'(fifo_wr_en), 64'(1));
      do_reset();
      for (int i = 0; i < N; i++) add_pkt(i, 2, 1'b1);
      en = 4'b1111;
      repeat (4) step();
      if (dut_grants.size() > 0) chk("post_rst_first", 64'(dut_grants[0]), 64'(0));
      else chk("post_rst_seen", 64'(0), 64'(1));

      // Random traffic with random backpressure and valid gaps.
      do_reset();
      for (int c = 0; c < 600; c++) begin
         en               = N'($urandom);
         fifo_full        = ($urandom_range(0, 4) == 0);
         fifo_almost_full = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 2) == 0) begin
            p = $urandom_range(0, N - 1);
            if (qd[p].size() < 24) add_pkt(p, $urandom_range(1, 12), 1'b1);
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the write port of one single-clock 32-bit FIFO between NUM_REQ producers.
- Round-robin arbitration with packet-granular grants: a grant is held until the producer's last beat or until MAX_BURST beats have transferred.
- Honours FIFO full/almost_full backpressure.
- Sits between the producers and the FIFO write side: drives wr_en/wr_data and observes full/almost_full.

Parameters:
- NUM_REQ, 4: number of requesting producers (2..8).
- DATA_W, 32: data width; matches the FIFO data width.
- MAX_BURST, 8: maximum beats per grant before a forced rotation (1..255).

Ports:
- clk, input, 1: single system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- req_valid, input, NUM_REQ: per-producer beat valid.
- req_data, input, NUM_REQ*DATA_W: per-producer data; producer i uses slice [i*DATA_W +: DATA_W].
- req_last, input, NUM_REQ: marks a producer's final beat of a packet.
- req_ready, output, NUM_REQ: per-producer beat accepted this cycle.
- fifo_wr_en, output, 1: FIFO write strobe.
- fifo_wr_data, output, DATA_W: FIFO write data.
- fifo_full, input, 1: FIFO full.
- fifo_almost_full, input, 1: FIFO almost full.
- grant_id, output, $clog2(NUM_REQ): index of the current or last granted producer.
- busy, output, 1: a grant is active.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- FSM states: IDLE, BURST. Registers: state, grant_id, rr_ptr, beat_cnt.
- Reset (asynchronous, including mid-burst): state=IDLE, grant_id=0, rr_ptr=0, beat_cnt=0. fifo_wr_en, req_ready, busy and fifo_wr_data go 0 immediately. No partial-packet recovery.
- IDLE:
  - If any req_valid and !fifo_almost_full, pick the first set req_valid scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - At the clock edge: grant_id=winner, rr_ptr=(winner+1) mod NUM_REQ, beat_cnt=0, state->BURST.
  - With fifo_almost_full high, no grant is issued and state stays IDLE.
- Grant latency: 1 cycle from req_valid to the first possible transfer.
- BURST:
  - busy=1.
  - Transfer condition, evaluated combinationally: xfer = req_valid[grant_id] & !fifo_full.
  - req_ready[grant_id]=xfer. All other req_ready bits are 0.
  - fifo_wr_en=xfer. fifo_wr_data = req_data slice of grant_id.
  - Zero-latency pass-through; no data register.
  - Each xfer increments beat_cnt.
  - Release to IDLE at the clock edge when xfer & (req_last[grant_id] | beat_cnt==MAX_BURST-1).
  - Grant is held while the granted producer drops req_valid; there is no timeout.
  - fifo_almost_full has no effect mid-burst; only fifo_full stalls.
- Post-release bubble: exactly one IDLE cycle before the next grant.
- Forced rotation at MAX_BURST does not terminate the producer's packet. The producer re-arbitrates and continues later.
- Outputs outside BURST: fifo_wr_en=0, fifo_wr_data=0, req_ready=0, busy=0. grant_id holds its last value.
- Simultaneous cases:
  - fifo_full and req_last in the same cycle: no transfer, no release.
  - req_last on beat MAX_BURST: a single release.
- The FIFO never receives wr_en while fifo_full=1.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum (IDLE, BURST);
  - localparams for ID_W=$clog2(NUM_REQ) and CNT_W=$clog2(MAX_BURST+1).
- Sub-module rr_pick: combinational rotating-priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: found, index.
  - Instantiated once in fifo_wr_arbiter.

Test Plan:
- Single packet: only req0 valid with 3 beats A1,A2,A3, last on A3 -> grant_id=0 one cycle after valid. fifo_wr_en high 3 consecutive cycles with A1..A3. busy drops the cycle after A3.
- Fairness: all 4 producers valid continuously with 2-beat packets -> grant order 0,1,2,3,0,1. Each grant gives 2 writes, with a 1-cycle gap between grants.
- Burst cap: MAX_BURST=8, req0 streams 20 beats with no last, req1 has 1 beat -> req0 8 beats, then req1 1 beat, then req0 resumes at beat 9.
- Full stall: fifo_full held high for 3 cycles mid-burst at beat 2 -> fifo_wr_en=0 and req_ready=0 for 3 cycles, grant and beat_cnt unchanged, beat 3 written after fifo_full drops.
- Almost-full gating: fifo_almost_full=1 while IDLE with req1,req2 valid -> no grant. After almost_full deasserts, grant_id=1 on the next cycle.
- Reset mid-burst: rst pulses at beat 4 of a req2 burst -> fifo_wr_en=0 and busy=0 immediately. After release with all producers requesting, the first grant goes to req0.
